// File: rtl/sticky_priority_scheduler_pkg.sv
// sticky_priority_scheduler_pkg: shared width constant and index-width helper for the scheduler.
package sticky_priority_scheduler_pkg;
  localparam int unsigned SPS_DEFAULT_WIDTH = 8;
  function automatic int unsigned sps_idx_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/sticky_priority_scheduler_first_one.sv
// first_one: isolates the lowest set bit of a vector (all-zero in, all-zero out).
module first_one
  import sticky_priority_scheduler_pkg::*;
#(
  parameter int WIDTH = SPS_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [WIDTH-1:0] out_onehot
);
  // x & -x keeps only the least significant one.
  assign out_onehot = in_vec & (-in_vec);
endmodule

// File: rtl/sticky_priority_scheduler.sv
// sticky_priority_scheduler: sticky pending register feeding a registered lowest-index-first grant port.
// Define STICKY_PRIORITY_SCHEDULER_INDEX_EN to add the binary grant_index output.
module sticky_priority_scheduler
  import sticky_priority_scheduler_pkg::*;
#(
  parameter int WIDTH = SPS_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] request,
  output logic [WIDTH-1:0] pending,
  output logic             grant_valid,
  input  logic             grant_ready,
`ifdef STICKY_PRIORITY_SCHEDULER_INDEX_EN
  output logic [sps_idx_w(WIDTH)-1:0] grant_index,
`endif
  output logic [WIDTH-1:0] grant_onehot
);
  logic [WIDTH-1:0] pending_q, pending_d, selected, grant_onehot_q, grant_onehot_d;
  logic             grant_valid_q, grant_valid_d, load;
  first_one #(.WIDTH(WIDTH)) u_first_one (.in_vec(pending_q), .out_onehot(selected));
  always_comb begin
    load           = (!grant_valid_q || grant_ready) && (|pending_q);
    pending_d      = (pending_q & ~(load ? selected : '0)) | request;
    grant_valid_d  = load ? 1'b1 : grant_ready ? 1'b0 : grant_valid_q;
    grant_onehot_d = load ? selected : grant_ready ? '0 : grant_onehot_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending_q      <= '0;
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
    end else begin
      pending_q      <= pending_d;
      grant_valid_q  <= grant_valid_d;
      grant_onehot_q <= grant_onehot_d;
    end
  end
  assign pending      = pending_q;
  assign grant_valid  = grant_valid_q;
  assign grant_onehot = grant_onehot_q;
`ifdef STICKY_PRIORITY_SCHEDULER_INDEX_EN
  localparam int IW = sps_idx_w(WIDTH);
  logic [IW-1:0] sel_index, grant_index_q, grant_index_d;
  // One-hot to binary: OR together the index of every set bit.
  always_comb begin
    sel_index = '0;
    for (int i = 0; i < WIDTH; i++) sel_index = sel_index | (selected[i] ? IW'(i) : '0);
    grant_index_d = load ? sel_index : grant_ready ? '0 : grant_index_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) grant_index_q <= '0;
    else grant_index_q <= grant_index_d;
  end
  assign grant_index = grant_index_q;
`endif
endmodule
